// File: rtl/stack_alu_seq.sv
// stack_alu_seq: clocked signed stack ALU with valid/ready commands and a shift-add multiplier
// Ports: clk, rst (async, active-high); opcode/input_data/op_valid/op_ready form the command
// handshake; output_data/overflow are qualified by the out_valid pulse; error pulses when a
// command is rejected; stack_empty/stack_full/depth_count report the registered stack status.
module stack_alu_seq #(
  parameter int N = 16,
  parameter int DEPTH = 8
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [2:0]                 opcode,
  input  logic [N-1:0]               input_data,
  input  logic                       op_valid,
  output logic                       op_ready,
  output logic [N-1:0]               output_data,
  output logic                       out_valid,
  output logic                       overflow,
  output logic                       error,
  output logic                       stack_empty,
  output logic                       stack_full,
  output logic [$clog2(DEPTH+1)-1:0] depth_count
);
  localparam int CW = $clog2(DEPTH + 1);
  localparam int AW = $clog2(DEPTH);
  localparam int KW = $clog2(N);
  typedef enum logic [1:0] {IDLE, MUL, DONE} state_t;
  state_t state_q, state_d;
  logic [CW-1:0] depth_q, depth_d;
  logic [N-1:0] stk_q [DEPTH];
  logic [N-1:0] stk_d [DEPTH];
  logic [N-1:0] data_q, data_d;
  logic ovf_q, ovf_d, valid_q, valid_d, err_q, err_d, empty_q, empty_d, full_q, full_d;
  logic [2*N-1:0] acc_q, acc_d, mcand_q, mcand_d;
  logic [N-1:0] mplier_q, mplier_d;
  logic neg_q, neg_d;
  logic [KW-1:0] bit_q, bit_d;
  logic [N-1:0] a, b, sum, dif, mag_a, mag_b;
  logic [2*N-1:0] prod;
  logic add_ovf, sub_ovf, mul_ovf;
  always_comb begin
    a = stk_q[AW'(depth_q - CW'(1))];
    b = stk_q[AW'(depth_q - CW'(2))];
    sum = b + a;
    dif = b - a;
    add_ovf = (a[N-1] == b[N-1]) && (sum[N-1] != b[N-1]);
    sub_ovf = (a[N-1] != b[N-1]) && (dif[N-1] != b[N-1]);
    mag_a = a[N-1] ? -a : a;
    mag_b = b[N-1] ? -b : b;
    prod = neg_q ? -acc_q : acc_q;
    // the product fits in N signed bits only if bits [2N-1:N-1] are pure sign extension
    mul_ovf = !((&prod[2*N-1:N-1]) || !(|prod[2*N-1:N-1]));
  end
  always_comb begin
    state_d = state_q;
    depth_d = depth_q;
    stk_d = stk_q;
    data_d = data_q;
    ovf_d = ovf_q;
    valid_d = 1'b0;
    err_d = 1'b0;
    acc_d = acc_q;
    mcand_d = mcand_q;
    mplier_d = mplier_q;
    neg_d = neg_q;
    bit_d = bit_q;
    case (state_q)
      IDLE:
        if (op_valid)
          case (opcode)
            3'b110:
              if (full_q) err_d = 1'b1;
              else begin
                stk_d[AW'(depth_q)] = input_data;
                depth_d = depth_q + CW'(1);
                data_d = input_data;
                ovf_d = 1'b0;
                valid_d = 1'b1;
              end
            3'b111:
              if (empty_q) err_d = 1'b1;
              else begin
                depth_d = depth_q - CW'(1);
                data_d = a;
                ovf_d = 1'b0;
                valid_d = 1'b1;
              end
            3'b010:
              if (empty_q || full_q) err_d = 1'b1;
              else begin
                stk_d[AW'(depth_q)] = a;
                depth_d = depth_q + CW'(1);
                data_d = a;
                ovf_d = 1'b0;
                valid_d = 1'b1;
              end
            3'b011:
              if (depth_q < CW'(2)) err_d = 1'b1;
              else begin
                stk_d[AW'(depth_q - CW'(1))] = b;
                stk_d[AW'(depth_q - CW'(2))] = a;
                data_d = b;
                ovf_d = 1'b0;
                valid_d = 1'b1;
              end
            3'b100, 3'b001:
              if (depth_q < CW'(2)) err_d = 1'b1;
              else begin
                stk_d[AW'(depth_q - CW'(2))] = opcode[2] ? sum : dif;
                depth_d = depth_q - CW'(1);
                data_d = opcode[2] ? sum : dif;
                ovf_d = opcode[2] ? add_ovf : sub_ovf;
                valid_d = 1'b1;
              end
            3'b101:
              if (depth_q < CW'(2)) err_d = 1'b1;
              else begin
                mcand_d = {{N{1'b0}}, mag_a};
                mplier_d = mag_b;
                acc_d = '0;
                bit_d = '0;
                neg_d = a[N-1] ^ b[N-1];
                depth_d = depth_q - CW'(2);
                state_d = MUL;
              end
            default: ;
          endcase
      MUL: begin
        acc_d = acc_q + (mplier_q[0] ? mcand_q : '0);
        mcand_d = mcand_q << 1;
        mplier_d = mplier_q >> 1;
        bit_d = bit_q + KW'(1);
        state_d = (bit_q == KW'(N - 1)) ? DONE : MUL;
      end
      DONE: begin
        stk_d[AW'(depth_q)] = prod[N-1:0];
        depth_d = depth_q + CW'(1);
        data_d = prod[N-1:0];
        ovf_d = mul_ovf;
        valid_d = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    empty_d = depth_d == '0;
    full_d = depth_d == CW'(DEPTH);
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state_q <= IDLE;
      depth_q <= '0;
      data_q <= '0;
      ovf_q <= 1'b0;
      valid_q <= 1'b0;
      err_q <= 1'b0;
      empty_q <= 1'b1;
      full_q <= 1'b0;
      acc_q <= '0;
      mcand_q <= '0;
      mplier_q <= '0;
      neg_q <= 1'b0;
      bit_q <= '0;
    end else begin
      state_q <= state_d;
      depth_q <= depth_d;
      data_q <= data_d;
      ovf_q <= ovf_d;
      valid_q <= valid_d;
      err_q <= err_d;
      empty_q <= empty_d;
      full_q <= full_d;
      acc_q <= acc_d;
      mcand_q <= mcand_d;
      mplier_q <= mplier_d;
      neg_q <= neg_d;
      bit_q <= bit_d;
    end
  always_ff @(posedge clk) stk_q <= stk_d;
  assign op_ready = state_q == IDLE;
  assign output_data = data_q;
  assign out_valid = valid_q;
  assign overflow = ovf_q;
  assign error = err_q;
  assign stack_empty = empty_q;
  assign stack_full = full_q;
  assign depth_count = depth_q;
endmodule

// File: tb/tb_stack_alu_seq.sv
// tb_stack_alu_seq: randomized and directed checks of stack_alu_seq against a queue-based model
module tb_stack_alu_seq;
  localparam int N = 8;
  localparam int DEPTH = 4;
  localparam logic [2:0] NOP = 3'b000, SUB = 3'b001, DUP = 3'b010, SWAP = 3'b011;
  localparam logic [2:0] ADD = 3'b100, MUL = 3'b101, PUSH = 3'b110, POP = 3'b111;
  logic clk = 1'b0, rst = 1'b1, op_valid = 1'b0;
  logic [2:0] opcode = NOP;
  logic [N-1:0] input_data = '0;
  logic op_ready, out_valid, overflow, error, stack_empty, stack_full;
  logic [N-1:0] output_data;
  logic [2:0] depth_count;
  int nchk = 0, nerr = 0;
  int stk[$];
  int m_out = 0;
  bit m_ovf = 1'b0;
  stack_alu_seq #(.N(N), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .opcode(opcode), .input_data(input_data), .op_valid(op_valid),
    .op_ready(op_ready), .output_data(output_data), .out_valid(out_valid), .overflow(overflow),
    .error(error), .stack_empty(stack_empty), .stack_full(stack_full), .depth_count(depth_count)
  );
  always #5 clk = ~clk;
  function automatic int wrap(input int r);
    logic [7:0] t;
    t = 8'(r);
    return int'($signed(t));
  endfunction
  function automatic logic [16:0] obs();
    return {op_ready, out_valid, error, overflow, stack_empty, stack_full, depth_count, output_data};
  endfunction
  function automatic logic [16:0] expv(input bit v, input bit e);
    int d = stk.size();
    return {1'b1, v, e, m_ovf, d == 0, d == DEPTH, 3'(d), 8'(m_out)};
  endfunction
  task automatic exec(input string tag, input logic [2:0] op, input logic [N-1:0] d);
    int n = stk.size();
    int a, b, r;
    bit e = 0, v = 1, m = 0;
    a = n > 0 ? stk[n-1] : 0;
    b = n > 1 ? stk[n-2] : 0;
    case (op)
      NOP: v = 0;
      PUSH: if (n == DEPTH) e = 1; else begin m_out = wrap(int'(d)); stk.push_back(m_out); m_ovf = 0; end
      POP: if (n < 1) e = 1; else begin void'(stk.pop_back()); m_out = a; m_ovf = 0; end
      DUP: if (n < 1 || n == DEPTH) e = 1; else begin stk.push_back(a); m_out = a; m_ovf = 0; end
      SWAP: if (n < 2) e = 1; else begin stk[n-1] = b; stk[n-2] = a; m_out = b; m_ovf = 0; end
      default:
        if (n < 2) e = 1;
        else begin
          r = op == ADD ? b + a : op == SUB ? b - a : b * a;
          m_ovf = r > 127 || r < -128;
          m_out = wrap(r);
          void'(stk.pop_back());
          void'(stk.pop_back());
          stk.push_back(m_out);
          m = op == MUL;
        end
    endcase
    if (e) v = 0;
    opcode = op;
    input_data = d;
    op_valid = 1'b1;
    @(posedge clk); #1;
    if (m) begin
      opcode = PUSH;
      input_data = 8'($urandom);
      for (int i = 0; i <= N; i++) begin
        nchk++;
        if (op_ready !== 1'b0 || out_valid !== 1'b0) begin
          nerr++;
          $display("FAIL %s busy cycle %0d: op_ready=%b out_valid=%b, want 0 0", tag, i, op_ready, out_valid);
        end
        if (i == N) op_valid = 1'b0;
        @(posedge clk); #1;
      end
    end else op_valid = 1'b0;
    nchk++;
    if (obs() !== expv(v, e)) begin
      nerr++;
      $display("FAIL %s op=%0d: {rdy,vld,err,ovf,emp,full,depth,data} got %h want %h", tag, op, obs(), expv(v, e));
    end
  endtask
  task automatic gap(input string tag);
    op_valid = 1'b0;
    @(posedge clk); #1;
    nchk++;
    if (out_valid !== 1'b0 || error !== 1'b0) begin
      nerr++;
      $display("FAIL %s pulse: out_valid=%b error=%b want 0 0", tag, out_valid, error);
    end
  endtask
  task automatic clear();
    while (stk.size() > 0) exec("clear", POP, '0);
  endtask
  task automatic test_reset();
    repeat (2) @(posedge clk);
    #1;
    nchk++;
    if (obs() !== 17'b1_0_0_0_1_0_000_00000000) begin
      nerr++;
      $display("FAIL reset: got %h want %h", obs(), 17'b1_0_0_0_1_0_000_00000000);
    end
    rst = 1'b0;
    @(posedge clk); #1;
  endtask
  task automatic test_add();
    clear();
    exec("add_p1", PUSH, 8'h03);
    exec("add_p2", PUSH, 8'h04);
    exec("add", ADD, '0);
    nchk++;
    if (output_data !== 8'h07 || overflow !== 1'b0 || depth_count !== 3'd1) begin
      nerr++;
      $display("FAIL add_plan: data=%h ovf=%b depth=%0d want 07 0 1", output_data, overflow, depth_count);
    end
    gap("add");
  endtask
  task automatic test_mul();
    clear();
    exec("mul_p1", PUSH, 8'hEB);
    exec("mul_p2", PUSH, 8'h0A);
    exec("mul", MUL, '0);
    nchk++;
    if (output_data !== 8'h2E || overflow !== 1'b1 || depth_count !== 3'd1) begin
      nerr++;
      $display("FAIL mul_plan: data=%h ovf=%b depth=%0d want 2e 1 1", output_data, overflow, depth_count);
    end
    exec("mul_p3", PUSH, 8'hFA);
    exec("mul_p4", PUSH, 8'hFB);
    exec("mul_negneg", MUL, '0);
    nchk++;
    if (output_data !== 8'h1E || overflow !== 1'b0) begin
      nerr++;
      $display("FAIL mul_negneg: data=%h ovf=%b want 1e 0", output_data, overflow);
    end
    exec("mul_p5", PUSH, 8'h80);
    exec("mul_p6", PUSH, 8'h80);
    exec("mul_minmin", MUL, '0);
    exec("mul_p7", PUSH, 8'h10);
    exec("mul_minneg", PUSH, 8'hF8);
    exec("mul_edge", MUL, '0);
    clear();
    exec("mul_p8", PUSH, 8'h01);
    exec("mul_short", MUL, '0);
    gap("mul");
  endtask
  task automatic test_full_empty();
    clear();
    for (int i = 1; i <= 4; i++) exec("fill", PUSH, 8'(i));
    nchk++;
    if (stack_full !== 1'b1 || depth_count !== 3'd4) begin
      nerr++;
      $display("FAIL full_flag: full=%b depth=%0d want 1 4", stack_full, depth_count);
    end
    exec("push_full", PUSH, 8'h05);
    exec("dup_full", DUP, '0);
    for (int i = 4; i >= 1; i--) begin
      exec("drain", POP, '0);
      nchk++;
      if (output_data !== 8'(i)) begin
        nerr++;
        $display("FAIL drain_order: data=%h want %h", output_data, 8'(i));
      end
    end
    exec("pop_empty", POP, '0);
    nchk++;
    if (output_data !== 8'h01 || error !== 1'b1 || stack_empty !== 1'b1) begin
      nerr++;
      $display("FAIL pop_empty_plan: data=%h err=%b empty=%b want 01 1 1", output_data, error, stack_empty);
    end
    exec("dup_empty", DUP, '0);
    for (int i = 0; i < 4; i++) exec("refill", PUSH, 8'($urandom));
    exec("add_full", ADD, '0);
    exec("mul_full", MUL, '0);
    gap("full");
  endtask
  task automatic test_swap_sub();
    clear();
    exec("ss_p1", PUSH, 8'h02);
    exec("ss_p2", PUSH, 8'h05);
    exec("swap", SWAP, '0);
    nchk++;
    if (output_data !== 8'h02) begin
      nerr++;
      $display("FAIL swap_plan: data=%h want 02", output_data);
    end
    exec("sub", SUB, '0);
    nchk++;
    if (output_data !== 8'h03 || overflow !== 1'b0) begin
      nerr++;
      $display("FAIL sub_plan: data=%h ovf=%b want 03 0", output_data, overflow);
    end
    exec("ss_p3", PUSH, 8'h80);
    exec("ss_p4", PUSH, 8'h01);
    exec("sub_ovf", SUB, '0);
    nchk++;
    if (output_data !== 8'h7F || overflow !== 1'b1) begin
      nerr++;
      $display("FAIL sub_ovf_plan: data=%h ovf=%b want 7f 1", output_data, overflow);
    end
    exec("ss_p5", PUSH, 8'h01);
    exec("add_ovf", ADD, '0);
    exec("swap_clr", SWAP, '0);
    gap("swap");
  endtask
  task automatic test_back_to_back();
    clear();
    exec("b2b_p1", PUSH, 8'h11);
    exec("b2b_p2", PUSH, 8'h22);
    exec("b2b_dup", DUP, '0);
    exec("b2b_add", ADD, '0);
    exec("b2b_sub", SUB, '0);
    exec("b2b_nop", NOP, '0);
    exec("b2b_pop", POP, '0);
    gap("b2b");
  endtask
  task automatic test_reset_mid_mul();
    clear();
    exec("rm_p1", PUSH, 8'h03);
    exec("rm_p2", PUSH, 8'h07);
    opcode = MUL;
    op_valid = 1'b1;
    @(posedge clk); #1;
    op_valid = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    stk.delete();
    m_out = 0;
    m_ovf = 0;
    nchk++;
    if (obs() !== expv(0, 0)) begin
      nerr++;
      $display("FAIL reset_mid_mul: got %h want %h", obs(), expv(0, 0));
    end
    @(posedge clk); #1;
    rst = 1'b0;
    exec("rm_push", PUSH, 8'h09);
    nchk++;
    if (output_data !== 8'h09 || depth_count !== 3'd1) begin
      nerr++;
      $display("FAIL reset_recover: data=%h depth=%0d want 09 1", output_data, depth_count);
    end
    gap("rm");
  endtask
  task automatic test_random();
    for (int i = 0; i < 300; i++) begin
      exec("rand", 3'($urandom_range(0, 7)), 8'($urandom));
      if ($urandom_range(0, 3) == 0) gap("rand");
    end
  endtask
  initial begin
    test_reset();
    test_add();
    test_mul();
    test_full_empty();
    test_swap_sub();
    test_back_to_back();
    test_reset_mid_mul();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
    $finish;
  end
endmodule
